// File: rtl/svc_rv_stage_if.sv
// rtl/svc_rv_stage_if.sv - RISC-V instruction fetch stage: PC, next-PC select, imem port, IF/ID outputs
// Optional misaligned-fetch flag enabled by defining SVC_RV_IF_MISALIGN_CHECK_EN.
module svc_rv_stage_if #(
  parameter int XLEN = 32,
  parameter int PIPELINED = 0,
  parameter int MEM_TYPE = 0,
  parameter int BPRED = 0,
  parameter int BTB_ENABLE = 0,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_stall,
  input  logic            if_id_stall,
  input  logic            if_id_flush,
  input  logic            redirect_ex,
  input  logic [XLEN-1:0] redirect_target_ex,
  input  logic [1:0]      pc_sel_id,
  input  logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] btb_pc,
  input  logic            btb_hit,
  input  logic            btb_taken,
  input  logic [XLEN-1:0] btb_target,
  output logic            imem_ren,
  output logic [31:0]     imem_raddr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_id,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic            btb_hit_id,
  output logic            btb_pred_taken_id,
  output logic [XLEN-1:0] btb_target_id,
  output logic            misaligned_id
);

  localparam logic [31:0]     NOP  = 32'h00000013;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam bit              BRAM = (PIPELINED != 0) && (MEM_TYPE != 0);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic            btb_use;

  assign pc_plus4 = pc_q + FOUR;
  assign btb_use  = (BPRED != 0) && (BTB_ENABLE != 0) && btb_hit && btb_taken;

  // EX redirect must win even over a stall; ID/BTB redirects wait for an unstalled cycle.
  always_comb begin
    pc_d = pc_q;
    if (redirect_ex) begin
      pc_d = redirect_target_ex;
    end else if (!pc_stall) begin
      if ((BPRED != 0) && (pc_sel_id == 2'b01)) pc_d = pred_target;
      else if (btb_use)                         pc_d = btb_target;
      else                                      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign btb_pc     = pc_q;
  assign imem_raddr = pc_q[31:0];
  // With BRAM the memory output register is the instruction register, so a held stage stops reads.
  assign imem_ren   = rst_n && !pc_stall && !(BRAM && if_id_stall);

  if (PIPELINED != 0) begin : g_pipe
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic [XLEN-1:0] pc_plus4_id_q, pc_plus4_id_d;
    logic [XLEN-1:0] btb_target_id_q, btb_target_id_d;
    logic            btb_hit_id_q, btb_hit_id_d;
    logic            btb_taken_id_q, btb_taken_id_d;

    always_comb begin
      instr_d         = instr_q;
      valid_d         = valid_q;
      pc_id_d         = pc_id_q;
      pc_plus4_id_d   = pc_plus4_id_q;
      btb_target_id_d = btb_target_id_q;
      btb_hit_id_d    = btb_hit_id_q;
      btb_taken_id_d  = btb_taken_id_q;
      if (if_id_flush) begin
        instr_d         = NOP;
        valid_d         = 1'b0;
        pc_id_d         = '0;
        pc_plus4_id_d   = '0;
        btb_target_id_d = '0;
        btb_hit_id_d    = 1'b0;
        btb_taken_id_d  = 1'b0;
      end else if (!if_id_stall) begin
        instr_d         = imem_rdata;
        valid_d         = imem_ren;
        pc_id_d         = pc_q;
        pc_plus4_id_d   = pc_plus4;
        btb_target_id_d = btb_target;
        btb_hit_id_d    = btb_hit;
        btb_taken_id_d  = btb_hit && btb_taken;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        instr_q         <= NOP;
        valid_q         <= 1'b0;
        pc_id_q         <= '0;
        pc_plus4_id_q   <= '0;
        btb_target_id_q <= '0;
        btb_hit_id_q    <= 1'b0;
        btb_taken_id_q  <= 1'b0;
      end else begin
        instr_q         <= instr_d;
        valid_q         <= valid_d;
        pc_id_q         <= pc_id_d;
        pc_plus4_id_q   <= pc_plus4_id_d;
        btb_target_id_q <= btb_target_id_d;
        btb_hit_id_q    <= btb_hit_id_d;
        btb_taken_id_q  <= btb_taken_id_d;
      end
    end

    assign instr_id          = BRAM ? (valid_q ? imem_rdata : NOP) : instr_q;
    assign pc_id             = pc_id_q;
    assign pc_plus4_id       = pc_plus4_id_q;
    assign btb_hit_id        = btb_hit_id_q;
    assign btb_pred_taken_id = btb_taken_id_q;
    assign btb_target_id     = btb_target_id_q;

`ifdef SVC_RV_IF_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    always_comb begin
      misaligned_d = misaligned_q;
      if (if_id_flush)       misaligned_d = 1'b0;
      else if (!if_id_stall) misaligned_d = (pc_q[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) misaligned_q <= 1'b0;
      else        misaligned_q <= misaligned_d;
    end

    assign misaligned_id = misaligned_q;
`else
    assign misaligned_id = 1'b0;
`endif
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl       = if_id_stall ^ if_id_flush;
    assign instr_id          = imem_rdata;
    assign pc_id             = pc_q;
    assign pc_plus4_id       = pc_plus4;
    assign btb_hit_id        = btb_hit;
    assign btb_pred_taken_id = btb_hit && btb_taken;
    assign btb_target_id     = btb_target;
`ifdef SVC_RV_IF_MISALIGN_CHECK_EN
    assign misaligned_id     = (pc_q[1:0] != 2'b00);
`else
    assign misaligned_id     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_svc_rv_stage_if.sv
// tb/tb_svc_rv_stage_if.sv - directed bench for svc_rv_stage_if
// Instances: a = IF/ID reg + comb imem + BPRED/BTB, b = BRAM imem, c = no IF/ID register.
module tb_svc_rv_stage_if;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef SVC_RV_IF_MISALIGN_CHECK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  logic        clk;
  logic        rst_n, pc_stall, if_id_stall, if_id_flush, redirect_ex;
  logic [31:0] redirect_target_ex, pred_target, btb_target;
  logic [1:0]  pc_sel_id;
  logic        btb_hit, btb_taken;

  logic [31:0] btb_pc_a, imem_raddr_a, imem_rdata_a, instr_id_a, pc_id_a, pc_plus4_id_a, btb_target_id_a;
  logic        imem_ren_a, btb_hit_id_a, btb_pred_taken_id_a, misaligned_id_a;
  logic [31:0] btb_pc_b, imem_raddr_b, imem_rdata_b, instr_id_b, pc_id_b, pc_plus4_id_b, btb_target_id_b;
  logic        imem_ren_b, btb_hit_id_b, btb_pred_taken_id_b, misaligned_id_b;
  logic [31:0] btb_pc_c, imem_raddr_c, imem_rdata_c, instr_id_c, pc_id_c, pc_plus4_id_c, btb_target_id_c;
  logic        imem_ren_c, btb_hit_id_c, btb_pred_taken_id_c, misaligned_id_c;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h00500093;
  endfunction

  assign imem_rdata_a = mem_word(imem_raddr_a);
  assign imem_rdata_c = mem_word(imem_raddr_c);
  always @(posedge clk) if (imem_ren_b) imem_rdata_b <= mem_word(imem_raddr_b);

  svc_rv_stage_if #(.XLEN(32), .PIPELINED(1), .MEM_TYPE(0), .BPRED(1), .BTB_ENABLE(1), .RESET_PC(32'h0)) u_a (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .redirect_ex(redirect_ex), .redirect_target_ex(redirect_target_ex), .pc_sel_id(pc_sel_id),
    .pred_target(pred_target), .btb_pc(btb_pc_a), .btb_hit(btb_hit), .btb_taken(btb_taken),
    .btb_target(btb_target), .imem_ren(imem_ren_a), .imem_raddr(imem_raddr_a), .imem_rdata(imem_rdata_a),
    .instr_id(instr_id_a), .pc_id(pc_id_a), .pc_plus4_id(pc_plus4_id_a), .btb_hit_id(btb_hit_id_a),
    .btb_pred_taken_id(btb_pred_taken_id_a), .btb_target_id(btb_target_id_a), .misaligned_id(misaligned_id_a));

  svc_rv_stage_if #(.XLEN(32), .PIPELINED(1), .MEM_TYPE(1), .BPRED(0), .BTB_ENABLE(0), .RESET_PC(32'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .redirect_ex(redirect_ex), .redirect_target_ex(redirect_target_ex), .pc_sel_id(pc_sel_id),
    .pred_target(pred_target), .btb_pc(btb_pc_b), .btb_hit(btb_hit), .btb_taken(btb_taken),
    .btb_target(btb_target), .imem_ren(imem_ren_b), .imem_raddr(imem_raddr_b), .imem_rdata(imem_rdata_b),
    .instr_id(instr_id_b), .pc_id(pc_id_b), .pc_plus4_id(pc_plus4_id_b), .btb_hit_id(btb_hit_id_b),
    .btb_pred_taken_id(btb_pred_taken_id_b), .btb_target_id(btb_target_id_b), .misaligned_id(misaligned_id_b));

  svc_rv_stage_if #(.XLEN(32), .PIPELINED(0), .MEM_TYPE(0), .BPRED(0), .BTB_ENABLE(0), .RESET_PC(32'h0)) u_c (
    .clk(clk), .rst_n(rst_n), .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .redirect_ex(redirect_ex), .redirect_target_ex(redirect_target_ex), .pc_sel_id(pc_sel_id),
    .pred_target(pred_target), .btb_pc(btb_pc_c), .btb_hit(btb_hit), .btb_taken(btb_taken),
    .btb_target(btb_target), .imem_ren(imem_ren_c), .imem_raddr(imem_raddr_c), .imem_rdata(imem_rdata_c),
    .instr_id(instr_id_c), .pc_id(pc_id_c), .pc_plus4_id(pc_plus4_id_c), .btb_hit_id(btb_hit_id_c),
    .btb_pred_taken_id(btb_pred_taken_id_c), .btb_target_id(btb_target_id_c), .misaligned_id(misaligned_id_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++; if (imem_ren_a !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b expected 0", imem_ren_a); end
    n_checks++; if (instr_id_a !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr_id_a, NOP); end
    n_checks++; if (pc_id_a !== 32'h0) begin n_fail++; $display("FAIL reset_pc_id: got %h expected 0", pc_id_a); end
    n_checks++; if (btb_hit_id_a !== 1'b0) begin n_fail++; $display("FAIL reset_btb_hit_id: got %b expected 0", btb_hit_id_a); end
    n_checks++; if (instr_id_b !== NOP) begin n_fail++; $display("FAIL reset_instr_b: got %h expected %h", instr_id_b, NOP); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_ren_a !== 1'b1) begin n_fail++; $display("FAIL release_ren: got %b expected 1", imem_ren_a); end
    n_checks++; if (imem_raddr_a !== 32'h0) begin n_fail++; $display("FAIL release_raddr: got %h expected 0", imem_raddr_a); end
    n_checks++; if (instr_id_a !== NOP) begin n_fail++; $display("FAIL release_instr: got %h expected %h", instr_id_a, NOP); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++; if (imem_raddr_a !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_raddr[%0d]: got %h expected %h", k, imem_raddr_a, 32'(4 * k)); end
      n_checks++; if (pc_id_a !== 32'(4 * (k - 1))) begin n_fail++; $display("FAIL seq_pc_id[%0d]: got %h expected %h", k, pc_id_a, 32'(4 * (k - 1))); end
      n_checks++; if (instr_id_a !== 32'h00500093 + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h", k, instr_id_a); end
    end
  endtask

  task automatic test_stall();
    pc_stall = 1'b1; if_id_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (imem_raddr_a !== 32'h10) begin n_fail++; $display("FAIL stall_raddr: got %h expected 10", imem_raddr_a); end
      n_checks++; if (pc_id_a !== 32'h0C) begin n_fail++; $display("FAIL stall_pc_id: got %h expected 0c", pc_id_a); end
      n_checks++; if (instr_id_a !== 32'h0050009F) begin n_fail++; $display("FAIL stall_instr: got %h expected 0050009f", instr_id_a); end
      n_checks++; if (imem_ren_b !== 1'b0) begin n_fail++; $display("FAIL stall_ren_b: got %b expected 0", imem_ren_b); end
    end
    pc_stall = 1'b0; if_id_stall = 1'b0;
    tick();
    n_checks++; if (imem_raddr_a !== 32'h14) begin n_fail++; $display("FAIL resume_raddr: got %h expected 14", imem_raddr_a); end
    n_checks++; if (pc_id_a !== 32'h10) begin n_fail++; $display("FAIL resume_pc_id: got %h expected 10", pc_id_a); end
  endtask

  task automatic test_redirect_priority();
    redirect_ex = 1'b1; redirect_target_ex = 32'h200;
    pc_sel_id = 2'b01; pred_target = 32'h100; pc_stall = 1'b1;
    tick();
    n_checks++; if (imem_raddr_a !== 32'h200) begin n_fail++; $display("FAIL ex_priority: got %h expected 200", imem_raddr_a); end
    n_checks++; if (imem_raddr_b !== 32'h200) begin n_fail++; $display("FAIL ex_priority_b: got %h expected 200", imem_raddr_b); end
    redirect_ex = 1'b0; pc_stall = 1'b0;
    tick();
    n_checks++; if (imem_raddr_a !== 32'h100) begin n_fail++; $display("FAIL id_pred: got %h expected 100", imem_raddr_a); end
    n_checks++; if (imem_raddr_b !== 32'h204) begin n_fail++; $display("FAIL no_bpred_b: got %h expected 204", imem_raddr_b); end
    pc_stall = 1'b1;
    tick();
    n_checks++; if (imem_raddr_a !== 32'h100) begin n_fail++; $display("FAIL stall_blocks_pred: got %h expected 100", imem_raddr_a); end
    pc_stall = 1'b0; pc_sel_id = 2'b00;
  endtask

  task automatic test_btb();
    redirect_ex = 1'b1; redirect_target_ex = 32'h40;
    tick();
    redirect_ex = 1'b0;
    n_checks++; if (imem_raddr_a !== 32'h40) begin n_fail++; $display("FAIL btb_setup: got %h expected 40", imem_raddr_a); end
    n_checks++; if (pc_id_c !== 32'h40) begin n_fail++; $display("FAIL comb_pc_id: got %h expected 40", pc_id_c); end
    n_checks++; if (instr_id_c !== 32'h005000D3) begin n_fail++; $display("FAIL comb_instr: got %h expected 005000d3", instr_id_c); end
    btb_hit = 1'b1; btb_taken = 1'b1; btb_target = 32'h80;
    #1;
    n_checks++; if (btb_pred_taken_id_c !== 1'b1) begin n_fail++; $display("FAIL comb_btb_taken: got %b expected 1", btb_pred_taken_id_c); end
    tick();
    n_checks++; if (imem_raddr_a !== 32'h80) begin n_fail++; $display("FAIL btb_next_pc: got %h expected 80", imem_raddr_a); end
    n_checks++; if (pc_id_a !== 32'h40) begin n_fail++; $display("FAIL btb_pc_id: got %h expected 40", pc_id_a); end
    n_checks++; if (btb_hit_id_a !== 1'b1) begin n_fail++; $display("FAIL btb_hit_id: got %b expected 1", btb_hit_id_a); end
    n_checks++; if (btb_pred_taken_id_a !== 1'b1) begin n_fail++; $display("FAIL btb_taken_id: got %b expected 1", btb_pred_taken_id_a); end
    n_checks++; if (btb_target_id_a !== 32'h80) begin n_fail++; $display("FAIL btb_target_id: got %h expected 80", btb_target_id_a); end
    btb_taken = 1'b0;
    tick();
    n_checks++; if (imem_raddr_a !== 32'h84) begin n_fail++; $display("FAIL btb_not_taken_pc: got %h expected 84", imem_raddr_a); end
    n_checks++; if (btb_pred_taken_id_a !== 1'b0) begin n_fail++; $display("FAIL btb_not_taken_id: got %b expected 0", btb_pred_taken_id_a); end
    btb_hit = 1'b0; btb_target = 32'h0;
  endtask

  task automatic test_flush_bram();
    redirect_ex = 1'b1; redirect_target_ex = 32'h0;
    tick();
    redirect_ex = 1'b0; if_id_flush = 1'b1;
    tick();
    n_checks++; if (instr_id_b !== NOP) begin n_fail++; $display("FAIL bram_flush_instr: got %h expected %h", instr_id_b, NOP); end
    n_checks++; if (instr_id_a !== NOP) begin n_fail++; $display("FAIL flush_instr_a: got %h expected %h", instr_id_a, NOP); end
    n_checks++; if (pc_plus4_id_a !== 32'h0) begin n_fail++; $display("FAIL flush_pc_plus4_a: got %h expected 0", pc_plus4_id_a); end
    if_id_flush = 1'b0;
    tick();
    n_checks++; if (instr_id_b !== 32'h00500097) begin n_fail++; $display("FAIL bram_after_flush: got %h expected 00500097", instr_id_b); end
    n_checks++; if (pc_id_b !== 32'h4) begin n_fail++; $display("FAIL bram_pc_id: got %h expected 4", pc_id_b); end
    n_checks++; if (pc_plus4_id_b !== 32'h8) begin n_fail++; $display("FAIL bram_pc_plus4: got %h expected 8", pc_plus4_id_b); end
    tick();
    n_checks++; if (instr_id_b !== 32'h0050009B) begin n_fail++; $display("FAIL bram_next: got %h expected 0050009b", instr_id_b); end
  endtask

  task automatic test_misalign();
    redirect_ex = 1'b1; redirect_target_ex = 32'h102;
    tick();
    redirect_ex = 1'b0;
    n_checks++; if (imem_raddr_a !== 32'h102) begin n_fail++; $display("FAIL mis_pc: got %h expected 102", imem_raddr_a); end
    n_checks++; if (misaligned_id_c !== EXP_MIS) begin n_fail++; $display("FAIL mis_comb: got %b expected %b", misaligned_id_c, EXP_MIS); end
    tick();
    n_checks++; if (pc_id_a !== 32'h102) begin n_fail++; $display("FAIL mis_pc_id: got %h expected 102", pc_id_a); end
    n_checks++; if (misaligned_id_a !== EXP_MIS) begin n_fail++; $display("FAIL mis_flag_a: got %b expected %b", misaligned_id_a, EXP_MIS); end
    n_checks++; if (misaligned_id_b !== EXP_MIS) begin n_fail++; $display("FAIL mis_flag_b: got %b expected %b", misaligned_id_b, EXP_MIS); end
  endtask

  task automatic test_flush_over_stall();
    if_id_flush = 1'b1; if_id_stall = 1'b1; pc_stall = 1'b1;
    tick();
    n_checks++; if (pc_id_a !== 32'h0) begin n_fail++; $display("FAIL flush_stall_pc_id: got %h expected 0", pc_id_a); end
    n_checks++; if (instr_id_a !== NOP) begin n_fail++; $display("FAIL flush_stall_instr: got %h expected %h", instr_id_a, NOP); end
    n_checks++; if (misaligned_id_a !== 1'b0) begin n_fail++; $display("FAIL flush_stall_mis: got %b expected 0", misaligned_id_a); end
    n_checks++; if (instr_id_b !== NOP) begin n_fail++; $display("FAIL flush_stall_instr_b: got %h expected %h", instr_id_b, NOP); end
    n_checks++; if (imem_raddr_a !== 32'h106) begin n_fail++; $display("FAIL flush_stall_pc: got %h expected 106", imem_raddr_a); end
    if_id_flush = 1'b0; if_id_stall = 1'b0; pc_stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pc_stall = 1'b0; if_id_stall = 1'b0; if_id_flush = 1'b0;
    redirect_ex = 1'b0; redirect_target_ex = 32'h0; pc_sel_id = 2'b00; pred_target = 32'h0;
    btb_hit = 1'b0; btb_taken = 1'b0; btb_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_priority();
    test_btb();
    test_flush_bram();
    test_misalign();
    test_flush_over_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
